seq_detector: RTL and testbench
===============================

SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, meaning pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning match-counter width.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port load, input, 1, capture pat_in as new pattern this cycle.
REQ-006 The block SHALL have port pat_in, input, PAT_W, pattern, MSB is first bit expected in time.
REQ-007 The block SHALL have port overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
REQ-008 The block SHALL have port x_valid, input, 1, qualifies x; x ignored when low.
REQ-009 The block SHALL have port x, input, 1, serial data bit.
REQ-010 The block SHALL have port y, output, 1, registered one-cycle match pulse.
REQ-011 The block SHALL have port match_cnt, output, CNT_W, saturating match count (present only with SEQ_DET_COUNT_EN).

Function
REQ-012 The FSM SHALL have states EMPTY (no pattern loaded), FILL (fewer than PAT_W valid bits collected), HUNT (window full, comparing).
REQ-013 EMPTY SHALL ignore x; load -> FILL, history and fill count cleared.
REQ-014 On every edge with x_valid=1 outside EMPTY, history SHALL shift left with x entering LSB; fill count increments, saturating at PAT_W.
REQ-015 FILL -> HUNT SHALL occur on the edge at which the PAT_W-th valid bit is sampled; that bit is eligible to match.
REQ-016 Match SHALL be {history[PAT_W-2:0], x} == stored pattern, with x_valid=1 and the window full after the shift.
REQ-017 On match, y SHALL be high for exactly the one cycle following the sampling edge; no combinational path from x to y.
REQ-018 On match with overlap=1, the FSM SHALL remain in HUNT with history intact.
REQ-019 On match with overlap=0, the FSM SHALL clear history and fill count and go to FILL.
REQ-020 overlap SHALL be sampled at the match edge; changing it between matches is legal.
REQ-021 x_valid=0 cycles SHALL hold all state; y low.
REQ-022 load in FILL or HUNT SHALL replace the pattern, clear history and fill count, go to FILL, and force y=0 that cycle.
REQ-023 load together with x_valid=1 SHALL give load priority; that x is discarded.
REQ-024 match_cnt SHALL increment by one per match and hold at 2^CNT_W-1; load does not clear it.

Reset
REQ-025 rst_n low SHALL immediately force state EMPTY, pattern 0, history 0, fill count 0, y=0, match_cnt=0.
REQ-026 Reset deassertion SHALL take effect at the next clk edge; reset mid-stream discards partial matches.

Configuration
REQ-027 With SEQ_DET_COUNT_EN defined, the counter and match_cnt port SHALL exist per REQ-024.
REQ-028 Without SEQ_DET_COUNT_EN, the counter logic and match_cnt port SHALL be absent; all other behaviour unchanged.

Structure
REQ-029 Package seq_det_pkg SHALL hold the state typedef (EMPTY/FILL/HUNT) and default PAT_W/CNT_W constants.
REQ-030 Sub-module seq_det_window SHALL contain the history shift register, fill counter and comparator, outputting hit and full; the FSM stays in seq_detector.

Verification
REQ-031 PAT_W=4, load 1011, overlap=1, stream 1,0,1,1,0,1,1 -> y pulses after bit 4 and bit 7; match_cnt=2.
REQ-032 Same stream, overlap=0 -> y pulses after bit 4 only; match_cnt=1.
REQ-033 Pattern 1011, stream 1,0,(x_valid=0 three cycles),1,1 -> single y pulse after last bit; y low during gap.
REQ-034 Stream 1,0,1 then load 0110 with x_valid=1 and x=1, then 0,1,1,0 -> no pulse on old pattern, y pulse after final 0.
REQ-035 Pattern 1011, stream 1,0,1, rst_n low mid-cycle -> y=0 and state EMPTY immediately; stream 1 after release -> no y.
REQ-036 CNT_W=2, 1111 pattern, overlap=1, eight 1s -> five pulses, match_cnt saturates at 3; build without macro shows identical y.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the serial pattern detector.
package seq_det_pkg;

    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        HUNT  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_det_window.sv
// Bit history, fill counter and pattern comparator for seq_detector.
// full/hit describe the window as it stands after this edge's shift.
module seq_det_window
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit,
    output logic             full
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    // The oldest bit falls out on the next shift, so only PAT_W-1 bits are kept.
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  w_window;

    assign w_window = {r_hist, x};
    assign full     = shift && (r_fill >= FILL_W'(PAT_W - 1));
    assign hit      = full && (w_window == pattern);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (shift) begin
            r_hist <= w_window[PAT_W-2:0];
            if (r_fill != FILL_W'(PAT_W))
                r_fill <= r_fill + FILL_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Loadable serial pattern detector with registered match pulse.
// Define SEQ_DET_COUNT_EN to add the saturating match counter and match_cnt port.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             x_valid,
    input  logic             x,
    output logic             y
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    if (PAT_W < 2 || PAT_W > 16 || CNT_W < 1) begin : g_illegal_params
        $error("seq_detector: PAT_W must be 2..16 and CNT_W at least 1");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [PAT_W-1:0] r_pat;
    logic             r_y;
    logic             w_shift;
    logic             w_clr;
    logic             w_hit;
    logic             w_full;

    // load wins over a coincident valid bit, which is dropped.
    assign w_shift = x_valid && !load && (r_state != EMPTY);

    seq_det_window #(.PAT_W(PAT_W)) u_window (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_clr),
        .shift   (w_shift),
        .x       (x),
        .pattern (r_pat),
        .hit     (w_hit),
        .full    (w_full)
    );

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_clr        = 1'b0;
        if (load) begin
            w_state_next = FILL;
            w_clr        = 1'b1;
        end else if (w_shift) begin
            if (w_hit && !overlap) begin
                w_state_next = FILL;
                w_clr        = 1'b1;
            end else if (w_full) begin
                w_state_next = HUNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_pat   <= '0;
            r_y     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_y     <= w_hit;
            if (load)
                r_pat <= pat_in;
        end
    end

    assign y = r_y;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_hit && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: overlap modes, gaps, reload, reset, saturation.
module tb_seq_detector;
    import seq_det_pkg::*;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             overlap;
    logic             x_valid;
    logic             x;
    logic             y;
`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .pat_in    (pat_in),
        .overlap   (overlap),
        .x_valid   (x_valid),
        .x         (x),
        .y         (y)
`ifdef SEQ_DET_COUNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int exp);
`ifdef SEQ_DET_COUNT_EN
        check(tag, 32'(match_cnt), exp);
`else
        if (exp < 0) $display("unexpected negative count for %s", tag);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        load    = 1'b0;
        x_valid = 1'b0;
        x       = 1'b0;
        pat_in  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_pattern(input logic [PAT_W-1:0] p, input logic v, input logic b,
                                input string tag);
        @(negedge clk);
        load    = 1'b1;
        pat_in  = p;
        x_valid = v;
        x       = b;
        @(posedge clk);
        #1;
        check({tag, "_y"}, 32'(y), 0);
        check({tag, "_state"}, 32'(dut.r_state), 32'(FILL));
        load = 1'b0;
    endtask

    task automatic step(input logic v, input logic b, input logic exp_y, input string tag);
        @(negedge clk);
        load    = 1'b0;
        x_valid = v;
        x       = b;
        @(posedge clk);
        #1;
        check(tag, 32'(y), 32'(exp_y));
    endtask

    // Bits and expected y are listed MSB first in time.
    task automatic stream(input string tag, input int n, input logic [15:0] bits,
                          input logic [15:0] exp);
        for (int i = 0; i < n; i++)
            step(1'b1, bits[n-1-i], exp[n-1-i], $sformatf("%s_bit%0d", tag, i + 1));
    endtask

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        pat_in  = '0;
        overlap = 1'b0;
        x_valid = 1'b0;
        x       = 1'b0;

        #12;
        check("reset_y", 32'(y), 0);
        check("reset_state", 32'(dut.r_state), 32'(EMPTY));
        check_cnt("reset_cnt", 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Without a loaded pattern x is ignored.
        step(1'b1, 1'b1, 1'b0, "empty_ignore");
        check("empty_state", 32'(dut.r_state), 32'(EMPTY));

        // Overlapping: 1011 found after bits 4 and 7.
        do_reset();
        overlap = 1'b1;
        load_pattern(4'b1011, 1'b0, 1'b0, "s1_load");
        stream("s1", 7, 16'b1011011, 16'b0001001);
        check("s1_state", 32'(dut.r_state), 32'(HUNT));
        check_cnt("s1_cnt", 2);

        // Non-overlapping: only the first match counts.
        do_reset();
        overlap = 1'b0;
        load_pattern(4'b1011, 1'b0, 1'b0, "s2_load");
        stream("s2", 7, 16'b1011011, 16'b0001000);
        check("s2_state", 32'(dut.r_state), 32'(FILL));
        check_cnt("s2_cnt", 1);

        // Invalid cycles hold state and keep y low.
        do_reset();
        overlap = 1'b1;
        load_pattern(4'b1011, 1'b0, 1'b0, "s3_load");
        step(1'b1, 1'b1, 1'b0, "s3_bit1");
        step(1'b1, 1'b0, 1'b0, "s3_bit2");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, $sformatf("s3_gap%0d", i));
        step(1'b1, 1'b1, 1'b0, "s3_bit3");
        step(1'b1, 1'b1, 1'b1, "s3_bit4");
        step(1'b0, 1'b0, 1'b0, "s3_pulse_end");

        // Reload with a coincident valid 1 that would have completed 1011.
        do_reset();
        overlap = 1'b1;
        load_pattern(4'b1011, 1'b0, 1'b0, "s4_load_old");
        stream("s4_old", 3, 16'b101, 16'b000);
        load_pattern(4'b0110, 1'b1, 1'b1, "s4_load_new");
        stream("s4_new", 4, 16'b0110, 16'b0001);

        // Mid-cycle reset while filling, then while y is high.
        do_reset();
        overlap = 1'b1;
        load_pattern(4'b1011, 1'b0, 1'b0, "s5_load");
        stream("s5a", 3, 16'b101, 16'b000);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_state", 32'(dut.r_state), 32'(EMPTY));
        check("s5_rst_y", 32'(y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        load_pattern(4'b1011, 1'b0, 1'b0, "s5_reload");
        stream("s5b", 4, 16'b1011, 16'b0001);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_y_high", 32'(y), 0);
        check_cnt("s5_rst_cnt", 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, "s5_after_release");
        check("s5_after_state", 32'(dut.r_state), 32'(EMPTY));

        // All-ones pattern: five overlapping hits, counter pinned at 3.
        do_reset();
        overlap = 1'b1;
        load_pattern(4'b1111, 1'b0, 1'b0, "s6_load");
        stream("s6", 8, 16'b11111111, 16'b00011111);
        check_cnt("s6_cnt_sat", 3);
        step(1'b0, 1'b0, 1'b0, "s6_idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
